lcd_bus_responder: RTL

- Target-side model of the character-LCD parallel bus (LCD_DATA/RS/RW/EN/RST) that the team's LCD writer blocks drive.
- Captures each bus transaction on the EN falling edge, decodes commands vs. data, and maintains a display RAM plus a cursor.
- Returns status/data on read cycles.
- Used as an on-chip mirror of display content and as the bench responder when verifying LCD writer FSMs.

---
 rtl/lcd_bus_responder.sv | 112 +++++++++++
 1 files changed

// File: rtl/lcd_bus_responder.sv
// Target-side model of the character-LCD parallel bus: commits on EN falling edge,
// mirrors display RAM and cursor. Optional drop/unknown-code error flag: LCD_RESP_ERR_EN.
module lcd_bus_responder #(
  parameter int         ADDR_W     = 5,
  parameter logic [7:0] CLEAR_CHAR = 8'h5F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        LCD_DATA,
  input  logic              LCD_RW,
  input  logic              LCD_EN,
  input  logic              LCD_RS,
  input  logic              LCD_RST,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] cursor,
  output logic              page_done,
  input  logic [ADDR_W-1:0] view_addr,
  output logic [7:0]        view_data,
  output logic              err
);
  localparam int                DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = '1;
  localparam logic [0:0]        S_IDLE  = 1'b0;
  localparam logic [0:0]        S_CLEAR = 1'b1;

  logic [0:0]        state;
  logic              en_d;
  logic [ADDR_W-1:0] fill_cnt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W+2:0] status;

  logic strobe, accept, wr_data, rd_adv, cmd;
  logic cmd_clear, cmd_home, cmd_addr;

  assign strobe    = en_d & ~LCD_EN;
  // Strobes only land in IDLE and never alongside a page restart.
  assign accept    = strobe & ~LCD_RST & (state == S_IDLE);
  assign wr_data   = accept & ~LCD_RW &  LCD_RS;
  assign rd_adv    = accept &  LCD_RW &  LCD_RS;
  assign cmd       = accept & ~LCD_RW & ~LCD_RS;
  assign cmd_clear = cmd & (LCD_DATA == 8'h01);
  assign cmd_home  = cmd & (LCD_DATA == 8'h02);
  assign cmd_addr  = cmd & LCD_DATA[7];

  assign busy      = (state == S_CLEAR);
  assign status    = {busy, 2'b00, cursor};
  assign view_data = mem[view_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      en_d      <= 1'b0;
      cursor    <= '0;
      fill_cnt  <= '0;
      page_done <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      en_d      <= LCD_EN;
      page_done <= 1'b0;
      if (LCD_EN && LCD_RW)
        rd_data <= LCD_RS ? mem[cursor] : 8'(status);
      case (state)
        S_IDLE: begin
          if (LCD_RST) begin
            cursor <= '0;
          end else if (wr_data || rd_adv) begin
            cursor    <= cursor + ADDR_W'(1);
            page_done <= (cursor == LAST);
          end else if (cmd_clear) begin
            state    <= S_CLEAR;
            fill_cnt <= '0;
          end else if (cmd_home) begin
            cursor <= '0;
          end else if (cmd_addr) begin
            cursor <= LCD_DATA[ADDR_W-1:0];
          end
        end
        default: begin
          fill_cnt <= fill_cnt + ADDR_W'(1);
          if (LCD_RST) cursor <= '0;
          if (fill_cnt == LAST) begin
            state  <= S_IDLE;
            cursor <= '0;
          end
        end
      endcase
    end
  end

  // RAM is never cleared by reset; a reset mid-fill leaves it partially filled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_CLEAR) mem[fill_cnt] <= CLEAR_CHAR;
      else if (wr_data)     mem[cursor]   <= LCD_DATA;
    end
  end

`ifdef LCD_RESP_ERR_EN
  logic drop_wr, cmd_bad;
  assign drop_wr = strobe & ~LCD_RW & (LCD_RST | (state == S_CLEAR));
  assign cmd_bad = cmd & ~(cmd_clear | cmd_home | cmd_addr);

  always_ff @(posedge clk) begin
    if (reset)                  err <= 1'b0;
    else if (drop_wr || cmd_bad) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
